right_shift_iter: RTL



---
 rtl/right_shift_iter_pkg.sv | 30 +++
 rtl/right_shift_iter_stage.sv | 26 ++
 rtl/right_shift_iter.sv | 109 ++++++++++
 3 files changed

// File: rtl/right_shift_iter_pkg.sv
// Shared types and helpers for the iterative right shifter.
// Holds the controller state encoding and the constant clog2 used for port and counter widths.
package right_shift_iter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Ceiling log2 evaluated at elaboration time; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Counter width for a given stage count, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned stages);
        int unsigned w;
        w = clog2(stages);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/right_shift_iter_stage.sv
// One binary stage of the right shifter: conditionally shifts by 2^k with zero or sign fill.
// Purely combinational; the top instantiates one per bit of the shift amount.
module right_shift_stage #(
    parameter int unsigned width = 8,
    parameter int unsigned k     = 0
) (
    input  logic [width-1:0] dIn,
    input  logic             en,
    input  logic             arith,
    output logic [width-1:0] dOut
);

    localparam int unsigned Amt = 1 << k;

    logic fill;

    assign fill = arith & dIn[width-1];

    always_comb begin
        dOut = dIn;
        if (en) begin
            dOut = {{Amt{fill}}, dIn[width-1:Amt]};
        end
    end

endmodule

// File: rtl/right_shift_iter.sv
// Sequential right shifter: resolves one binary stage of the shift amount per cycle,
// with valid/ready handshakes on both the request and the result side.
module right_shift_iter
    import right_shift_iter_pkg::*;
#(
    parameter int unsigned width = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      iValid,
    output logic                      iReady,
    input  logic [width-1:0]          iBits,
    input  logic [clog2(width)-1:0]   shift,
    input  logic                      arith,
    output logic                      oValid,
    input  logic                      oReady,
    output logic [width-1:0]          oBits
);

    localparam int unsigned SW = clog2(width);
    localparam int unsigned CW = cnt_width(SW);

    state_e          state_q;
    logic [width-1:0] data_q;
    logic [SW-1:0]    amt_q;
    logic             arith_q;
    logic [CW-1:0]    cnt_q;
    logic             valid_q;

    logic [width-1:0] stage_out [SW];
    logic [width-1:0] stage_sel;

    for (genvar g = 0; g < SW; g++) begin : g_stage
        right_shift_stage #(
            .width(width),
            .k    (g)
        ) u_stage (
            .dIn  (data_q),
            .en   (amt_q[g]),
            .arith(arith_q),
            .dOut (stage_out[g])
        );
    end

    always_comb begin
        stage_sel = stage_out[0];
        for (int k = 0; k < SW; k++) begin
            if (cnt_q == CW'(k)) begin
                stage_sel = stage_out[k];
            end
        end
    end

    // oValid is registered one cycle after entering DONE, giving a fixed SW+1 edge latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            amt_q   <= '0;
            arith_q <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (iValid) begin
                        data_q  <= iBits;
                        amt_q   <= shift;
                        arith_q <= arith;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    data_q <= stage_sel;
                    if (cnt_q == CW'(SW - 1)) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (oReady) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign iReady = (state_q == IDLE);
    assign oValid = valid_q;
    assign oBits  = data_q;

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
        (oValid && !oReady) |=> (oValid && $stable(oBits)));

    a_no_overlap: assert property (@(posedge clk) disable iff (!rst)
        !(iReady && oValid));

endmodule
